// File: rtl/audio_i2s_tx.sv
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : I2S transmitter for the WM8731 DAC (codec as slave). Generates
//                XCK/BCLK/LRCK and serialises crossfed stereo samples.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_i2s_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int BCLK_HALF = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] ldata,
    input  logic [SAMPLE_W-1:0] rdata,
    input  logic                exchan,
    input  logic                mix,
    output logic                sample_stb,
    output logic                aud_xck,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat
);

    localparam int c_word_w = 2 * SAMPLE_W;
    localparam int c_slot_w = $clog2(c_word_w);
    localparam int c_div_w  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int c_ext_w  = SAMPLE_W + 2;

    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(BCLK_HALF - 1);
    localparam logic [c_div_w-1:0]  c_div_one  = c_div_w'(1);
    localparam logic [c_slot_w-1:0] c_slot_one = c_slot_w'(1);

    logic [c_div_w-1:0]         r_div;
    logic [c_slot_w-1:0]        r_slot;
    logic [c_word_w-1:0]        r_word;

    logic [SAMPLE_W-1:0]        w_a;
    logic [SAMPLE_W-1:0]        w_b;
    logic signed [c_ext_w-1:0]  w_a_ext;
    logic signed [c_ext_w-1:0]  w_b_ext;
    logic signed [c_ext_w-1:0]  w_sum_l;
    logic signed [c_ext_w-1:0]  w_sum_r;
    logic signed [c_ext_w-1:0]  w_mix_l;
    logic signed [c_ext_w-1:0]  w_mix_r;
    logic [SAMPLE_W-1:0]        w_out_l;
    logic [SAMPLE_W-1:0]        w_out_r;
    logic [c_slot_w-1:0]        w_slot_next;
    logic [c_slot_w-1:0]        w_bit_idx;

    assign w_a     = exchan ? rdata : ldata;
    assign w_b     = exchan ? ldata : rdata;
    assign w_a_ext = {{2{w_a[SAMPLE_W-1]}}, w_a};
    assign w_b_ext = {{2{w_b[SAMPLE_W-1]}}, w_b};

    // 3*x + y fits in SAMPLE_W+2 signed bits even at full-scale negative input
    assign w_sum_l = (w_a_ext <<< 1) + w_a_ext + w_b_ext;
    assign w_sum_r = (w_b_ext <<< 1) + w_b_ext + w_a_ext;
    assign w_mix_l = w_sum_l >>> 2;
    assign w_mix_r = w_sum_r >>> 2;
    assign w_out_l = mix ? w_mix_l[SAMPLE_W-1:0] : w_a;
    assign w_out_r = mix ? w_mix_r[SAMPLE_W-1:0] : w_b;

    // Slot k carries word bit (2*SAMPLE_W - k) mod 2*SAMPLE_W; the frame word
    // width is a power of two, so both wraps fall out of modular arithmetic.
    assign w_slot_next = r_slot + c_slot_one;
    assign w_bit_idx   = ~w_slot_next + c_slot_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_slot      <= '0;
            r_word      <= '0;
            sample_stb  <= 1'b0;
            aud_xck     <= 1'b0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else begin
            aud_xck    <= ~aud_xck;
            sample_stb <= 1'b0;

            if (r_div == c_div_last) begin
                r_div    <= '0;
                aud_bclk <= ~aud_bclk;
                if (aud_bclk) begin
                    r_slot      <= w_slot_next;
                    aud_daclrck <= w_slot_next[c_slot_w-1];
                    aud_dacdat  <= r_word[w_bit_idx];
                    sample_stb  <= (w_slot_next == '0);
                end
            end else begin
                r_div <= r_div + c_div_one;
            end

            // The word is captured during the strobe cycle itself: slot 0 still
            // sends the old LSB, and slot 1 is the first reader of the new word.
            if (sample_stb) begin
                r_word <= {w_out_l, w_out_r};
            end
        end
    end

endmodule

`default_nettype wire
